// File: rtl/adc_deserializer.sv
// SPI master for a 12-bit AD7476-class ADC. Drives CSn/SCLK, shifts in one
// 16-bit frame per conversion and presents the 12 data bits as a parallel
// word with a single-cycle Valid strobe.
module adc_deserializer #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned QUIET_CYC = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        En,
    input  logic        SDATA,
    output logic        CSn,
    output logic        SCLK,
    output logic [11:0] DATAOUT,
    output logic        Valid,
    output logic        FrameErr
);

    localparam int unsigned DivW = $clog2(CLK_DIV);
    localparam int unsigned QW   = $clog2(QUIET_CYC + 1);

    localparam logic [DivW-1:0] DivLast   = DivW'(CLK_DIV - 1);
    // The IDLE cycle that sees this value is the last quiet cycle.
    localparam logic [QW-1:0]   QuietLast = QW'(QUIET_CYC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [3:0]        bit_q, bit_d;
    logic [15:0]       shift_q, shift_d;
    logic [QW-1:0]     quiet_q, quiet_d;
    logic              csn_q, csn_d;
    logic              sclk_q, sclk_d;
    logic [11:0]       data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;

    // Next-state logic: frame sequencing, SCLK division and bit capture.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        quiet_d = quiet_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        sclk_d  = 1'b1;

        unique case (state_q)
            StIdle: begin
                div_d = '0;
                bit_d = '0;
                if (quiet_q != QuietLast) begin
                    quiet_d = quiet_q + 1'b1;
                end
                if (En && (quiet_q == QuietLast)) begin
                    state_d = StConv;
                    quiet_d = '0;
                end
            end
            StConv: begin
                sclk_d = sclk_q;
                if (div_q == DivLast) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    // SCLK driven 0->1 on this edge: capture the bit the ADC
                    // shifted out on the preceding falling edge.
                    if (!sclk_q) begin
                        shift_d = {shift_q[14:0], SDATA};
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == 4'd15) begin
                            state_d = StDone;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StDone: begin
                data_d  = shift_q[11:0];
                valid_d = 1'b1;
                ferr_d  = |shift_q[15:12];
                quiet_d = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // CSn is registered from the next state so it tracks CONV exactly.
        csn_d = (state_d != StConv);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            quiet_q <= '0;
            csn_q   <= 1'b1;
            sclk_q  <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            quiet_q <= quiet_d;
            csn_q   <= csn_d;
            sclk_q  <= sclk_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign CSn      = csn_q;
    assign SCLK     = sclk_q;
    assign DATAOUT  = data_q;
    assign Valid    = valid_q;
    assign FrameErr = ferr_q;

endmodule
